// File: rtl/imem_uart_loader.sv
// ---------------------------------------------------------------------------
// imem_uart_loader
//   Serial program loader: the writer side of the instruction memory.
//   It receives 8N1 UART bytes and packs them big-endian into 32-bit words.
//   The words are written at byte addresses 0, 4, 8, ...
//   The CPU is held while loading is enabled.
//
// Optional feature: define LOADER_TIMEOUT_EN to drop a partial word after
//   TIMEOUT_CYC idle cycles, so that the host stream realigns. Default: off.
//
// Ports
//   clock       in   system clock
//   reset       in   asynchronous, active-high reset
//   uart_rxd    in   serial input, idle high, asynchronous to clock
//   load_en     in   loader enable (level, asynchronous)
//   cpu_hold    out  1 while the synchronised load_en is high
//   wr_en       out  one-cycle write strobe to the instruction memory
//   wr_addr     out  byte address of the word being written
//   wr_data     out  word being written (first byte received is in [31:24])
//   word_count  out  words written since the last load_en rise
//   frame_err   out  sticky flag: a stop bit was sampled low
// ---------------------------------------------------------------------------
module imem_uart_loader #(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = CLK_HZ / 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              uart_rxd,
    input  logic              load_en,
    output logic              cpu_hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] word_count,
    output logic              frame_err
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int TW  = $clog2(DIV);
    localparam logic [TW-1:0] HALF_LAST = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Each synchroniser is two flops. The rxd synchroniser resets to idle-high,
    // so that no start bit is seen when reset is released.
    logic rxd_meta_q, rxd_q, load_meta_q, load_q, load_prev_q;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              byte_ok, byte_bad;

    logic [23:0]       word_q, word_d;      // first three bytes of the word in progress
    logic [1:0]        idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic              ferr_q, ferr_d;

    logic load_rise, load_fall;
    assign load_rise = load_q & ~load_prev_q;
    assign load_fall = ~load_q & load_prev_q;

`ifdef LOADER_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic           to_run, to_hit;
    assign to_run   = load_q && (idx_q != 2'd0) && (state_q == S_IDLE);
    assign to_hit   = to_run && (to_cnt_q == TOW'(TIMEOUT_CYC - 1));
    assign to_cnt_d = (to_run && !to_hit) ? to_cnt_q + 1'b1 : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`endif

    // RX framing FSM. While the loader is disabled, the FSM is held in IDLE.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_ok   = 1'b0;
        byte_bad  = 1'b0;
        if (!load_q) begin
            state_d   = S_IDLE;
            timer_d   = '0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_q) begin
                        state_d = S_START;
                        timer_d = '0;
                    end
                end
                S_START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_d   = '0;
                        bit_cnt_d = '0;
                        // A line that is high again at mid-start-bit is a glitch.
                        state_d   = rxd_q ? S_IDLE : S_DATA;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (timer_q == FULL_LAST) begin
                        timer_d   = '0;
                        shift_d   = {rxd_q, shift_q[7:1]};   // LSB first
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) state_d = S_STOP;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (timer_q == FULL_LAST) begin
                        timer_d  = '0;
                        state_d  = S_IDLE;
                        byte_ok  = rxd_q;
                        byte_bad = ~rxd_q;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Word packing and the write port. The enable edges are handled last, so
    // they override everything else. byte_ok is never set while load_q is low,
    // so a disable in the same cycle as a 4th byte suppresses the write.
    always_comb begin
        word_d    = word_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        count_d   = count_q;
        ferr_d    = ferr_q;
        if (wr_en_q) begin
            wr_addr_d = wr_addr_q + ADDR_W'(4);
            count_d   = count_q + 1'b1;
        end
        if (byte_ok) begin
            word_d = {word_q[15:0], shift_q};
            idx_d  = idx_q + 1'b1;
            if (idx_q == 2'd3) begin
                wr_en_d   = 1'b1;
                wr_data_d = {word_q, shift_q};
            end
        end
        if (byte_bad) ferr_d = 1'b1;
`ifdef LOADER_TIMEOUT_EN
        if (to_hit) idx_d = 2'd0;
`endif
        if (load_fall) idx_d = 2'd0;
        if (load_rise) begin
            wr_addr_d = '0;
            count_d   = '0;
            idx_d     = 2'd0;
            ferr_d    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rxd_meta_q  <= 1'b1;
            rxd_q       <= 1'b1;
            load_meta_q <= 1'b0;
            load_q      <= 1'b0;
            load_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            idx_q       <= 2'd0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            count_q     <= '0;
            ferr_q      <= 1'b0;
        end else begin
            rxd_meta_q  <= uart_rxd;
            rxd_q       <= rxd_meta_q;
            load_meta_q <= load_en;
            load_q      <= load_meta_q;
            load_prev_q <= load_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            count_q     <= count_d;
            ferr_q      <= ferr_d;
        end
    end

    assign cpu_hold   = load_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = count_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with DIV = 10 and a short timeout.
module tb_imem_uart_loader;
    localparam int ADDR_W = 16;
    localparam int TO_CYC = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic              rxd;
    logic              load_en;
    logic              cpu_hold;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W-1:0] word_count;
    logic              frame_err;

    int vec_count   = 0;
    int miscompares = 0;
    int n_wr        = 0;
    logic [31:0] cap_addr = '0;
    logic [31:0] cap_data = '0;

    imem_uart_loader #(
        .CLK_HZ(1000000), .BAUD(100000), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clock(clk), .reset(rst), .uart_rxd(rxd), .load_en(load_en),
        .cpu_hold(cpu_hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .word_count(word_count), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Record every cycle with wr_en high. A pulse longer than one cycle
    // therefore shows up as an extra write.
    always @(negedge clk) begin
        if (wr_en) begin
            n_wr     <= n_wr + 1;
            cap_addr <= 32'(wr_addr);
            cap_data <= wr_data;
            $display("write: addr=%h data=%h", wr_addr, wr_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame. A bad stop bit is held low for only part of the bit
    // time, so that the line is high again when the receiver returns to IDLE.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rxd = 1'b0;
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(10);
        end
        if (stop_ok) begin
            rxd = 1'b1;
            tick(10);
        end else begin
            rxd = 1'b0;
            tick(7);
            rxd = 1'b1;
            tick(3);
        end
        tick(4);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
        tick(3);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cpu_hold"}, 32'(cpu_hold), 32'h0);
        check({tag, " wr_en"}, 32'(wr_en), 32'h0);
        check({tag, " wr_addr"}, 32'(wr_addr), 32'h0);
        check({tag, " wr_data"}, wr_data, 32'h0);
        check({tag, " word_count"}, 32'(word_count), 32'h0);
        check({tag, " frame_err"}, 32'(frame_err), 32'h0);
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; load_en = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(2);

        // 1: first word
        load_en = 1'b1;
        tick(5);
        check("hold_on", 32'(cpu_hold), 32'h1);
        send_word(32'h12345678);
        check("w1 writes", 32'(n_wr), 32'd1);
        check("w1 addr", cap_addr, 32'h0);
        check("w1 data", cap_data, 32'h12345678);
        check("w1 count", 32'(word_count), 32'd1);
        check("w1 next addr", 32'(wr_addr), 32'h4);

        // 2: second word, then toggle the enable
        send_word(32'hAABBCCDD);
        check("w2 writes", 32'(n_wr), 32'd2);
        check("w2 addr", cap_addr, 32'h4);
        check("w2 data", cap_data, 32'hAABBCCDD);
        check("w2 count", 32'(word_count), 32'd2);
        load_en = 1'b0;
        tick(5);
        check("off hold", 32'(cpu_hold), 32'h0);
        check("off addr kept", 32'(wr_addr), 32'h8);
        check("off count kept", 32'(word_count), 32'd2);
        check("off data kept", wr_data, 32'hAABBCCDD);
        load_en = 1'b1;
        tick(5);
        check("rise addr", 32'(wr_addr), 32'h0);
        check("rise count", 32'(word_count), 32'd0);
        check("rise hold", 32'(cpu_hold), 32'h1);

        // 3: glitch, then a framing error, then a clean word
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        check("glitch writes", 32'(n_wr), 32'd2);
        check("glitch ferr", 32'(frame_err), 32'h0);
        send_byte(8'h55, 1'b0);
        check("ferr set", 32'(frame_err), 32'h1);
        send_word(32'h11223344);
        check("after ferr writes", 32'(n_wr), 32'd3);
        check("after ferr addr", cap_addr, 32'h0);
        check("after ferr data", cap_data, 32'h11223344);

        // 4: a partial word is discarded by an enable toggle
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        load_en = 1'b0;
        tick(5);
        load_en = 1'b1;
        tick(5);
        check("rise clears ferr", 32'(frame_err), 32'h0);
        send_word(32'h01020304);
        check("realign writes", 32'(n_wr), 32'd4);
        check("realign addr", cap_addr, 32'h0);
        check("realign data", cap_data, 32'h01020304);
        check("realign count", 32'(word_count), 32'd1);

        // 5: one byte, a long idle gap, then a word
        send_byte(8'h99, 1'b1);
        tick(TO_CYC + 10);
        send_word(32'h01020304);
        check("timeout writes", 32'(n_wr), 32'd5);
        check("timeout addr", cap_addr, 32'h4);
`ifdef LOADER_TIMEOUT_EN
        check("timeout data", cap_data, 32'h01020304);
`else
        check("timeout data", cap_data, 32'h99010203);
`endif
        check("timeout count", 32'(word_count), 32'd2);

        // 6: asynchronous reset in the middle of a byte
        send_byte(8'h00, 1'b0);
        check("pre-reset ferr", 32'(frame_err), 32'h1);
        rxd = 1'b0;
        tick(10);
        rxd = 1'b1; tick(10);
        rxd = 1'b0; tick(10);
        rxd = 1'b1; tick(4);
        #2 rst = 1'b1;
        #1;
        check_all_zero("async reset");
        tick(3);
        rst = 1'b0;
        tick(6);
        check("post-reset hold", 32'(cpu_hold), 32'h1);
        send_word(32'hCAFEBABE);
        check("post-reset writes", 32'(n_wr), 32'd6);
        check("post-reset addr", cap_addr, 32'h0);
        check("post-reset data", cap_data, 32'hCAFEBABE);
        check("post-reset count", 32'(word_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
